// File: rtl/board_pwr_mgr.sv
// Board power manager: button synchronise/debounce plus core reset/shutdown sequencing.
// Optional macro BOA_PWR_WAKE_EN lets masked button presses wake the board from shutdown.
module board_pwr_mgr #(
  parameter int unsigned     NBTN       = 5,
  parameter int unsigned     DEB_CYCLES = 50000,
  parameter int unsigned     RST_CYCLES = 16,
  parameter int unsigned     RST_BTN    = 0,
  parameter logic [NBTN-1:0] WAKE_MASK  = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn,
  input  logic            pmu_rst,
  input  logic            pmu_shdn,
  output logic [NBTN-1:0] btn_db,
  output logic [NBTN-1:0] btn_press,
  output logic            core_rst,
  output logic            core_shdn,
  output logic [1:0]      pwr_state
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);
  localparam logic [RstW-1:0] RstMax = RstW'(RST_CYCLES - 1);

`ifdef BOA_PWR_WAKE_EN
  localparam bit WakeEn = 1'b1;
`else
  localparam bit WakeEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StRun   = 2'd1,
    StShdn  = 2'd2
  } pwr_state_e;

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] db_q, db_d;
  logic [NBTN-1:0] press_q, press_d;
  logic [DebW-1:0] deb_cnt_q [NBTN];
  logic [DebW-1:0] deb_cnt_d [NBTN];

  pwr_state_e      state_q, state_d;
  logic [RstW-1:0] rcnt_q, rcnt_d;
  logic            core_rst_q, core_shdn_q;
  logic            hold, wake;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Counter counts consecutive cycles of disagreement; the toggle lands on the DEB_CYCLES-th one.
  always_comb begin
    db_d    = db_q;
    press_d = '0;
    for (int i = 0; i < NBTN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          db_d[i]    = ~db_q[i];
          press_d[i] = ~db_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      db_q    <= db_d;
      press_q <= press_d;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign hold = db_q[RST_BTN] | pmu_rst;
  assign wake = WakeEn & (|(press_q & WAKE_MASK));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      StReset: begin
        if (hold) begin
          rcnt_d = '0;
        end else if (rcnt_q == RstMax) begin
          state_d = StRun;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StRun: begin
        // Reset takes priority over a simultaneous shutdown request.
        if (hold) begin
          state_d = StReset;
          rcnt_d  = '0;
        end else if (pmu_shdn) begin
          state_d = StShdn;
        end
      end
      StShdn: begin
        if (hold || wake) begin
          state_d = StReset;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = StReset;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReset;
      rcnt_q      <= '0;
      core_rst_q  <= 1'b1;
      core_shdn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      core_rst_q  <= (state_d == StReset);
      core_shdn_q <= (state_d == StShdn);
    end
  end

  assign btn_db    = db_q;
  assign btn_press = press_q;
  assign core_rst  = core_rst_q;
  assign core_shdn = core_shdn_q;
  assign pwr_state = state_q;

endmodule
